// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the ASCON-128 datapath.
// Steps one permutation round per clock through initialisation, one
// associated-data block, NB_BLOCKS plaintext blocks and finalisation.
//
// Handshake: data_ready_o is high only while waiting for a block. A block
// transfers on a rising edge where data_valid_i and data_ready_o are both
// high. The source must hold the block until that edge. data_valid_i is
// ignored while data_ready_o is low.
module ascon_ctrl_fsm #(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       init_state_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_end_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       cipher_valid_o,
    output logic       end_o,
    output logic [2:0] state_o
);

    localparam int BW = $clog2(NB_BLOCKS) + 1;
    localparam logic [BW-1:0] LAST_BLK = BW'(NB_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_AD,
        S_ASSOC,
        S_WAIT_PT,
        S_TEXT,
        S_FINAL,
        S_END
    } state_t;

    state_t        state, state_n;
    logic [3:0]    rnd, rnd_n;
    logic [BW-1:0] blk, blk_n;
    logic          cipher_valid_q;

    // State, round counter, block counter and the cipher-valid flag register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state          <= S_IDLE;
            rnd            <= 4'd0;
            blk            <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state          <= state_n;
            rnd            <= rnd_n;
            blk            <= blk_n;
            cipher_valid_q <= en_cipher_o;
        end
    end

    // Next state and Moore outputs; rnd returns to 0 whenever no round runs.
    always_comb begin
        state_n          = state;
        rnd_n            = rnd;
        blk_n            = blk;
        data_ready_o     = 1'b0;
        init_state_o     = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_end_o = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        end_o            = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_INIT;
                    rnd_n   = 4'd0;
                    blk_n   = '0;
                end
            end
            S_INIT: begin
                en_reg_state_o = 1'b1;
                init_state_o   = (rnd == 4'd0);
                if (rnd == 4'd11) begin
                    en_xor_key_end_o = 1'b1;
                    state_n          = S_WAIT_AD;
                    rnd_n            = 4'd0;
                end else begin
                    rnd_n = rnd + 4'd1;
                end
            end
            S_WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    state_n = S_ASSOC;
                    rnd_n   = 4'd6;
                end
            end
            S_ASSOC: begin
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (rnd == 4'd6);
                if (rnd == 4'd11) begin
                    en_xor_lsb_end_o = 1'b1;
                    state_n          = S_WAIT_PT;
                    rnd_n            = 4'd0;
                    blk_n            = '0;
                end else begin
                    rnd_n = rnd + 4'd1;
                end
            end
            S_WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    // The last block is absorbed by finalisation, not TEXT.
                    if (blk < LAST_BLK) begin
                        state_n = S_TEXT;
                        rnd_n   = 4'd6;
                    end else begin
                        state_n = S_FINAL;
                        rnd_n   = 4'd0;
                    end
                end
            end
            S_TEXT: begin
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (rnd == 4'd6);
                en_cipher_o    = (rnd == 4'd6);
                if (rnd == 4'd11) begin
                    blk_n   = blk + 1'b1;
                    state_n = S_WAIT_PT;
                    rnd_n   = 4'd0;
                end else begin
                    rnd_n = rnd + 4'd1;
                end
            end
            S_FINAL: begin
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (rnd == 4'd0);
                en_xor_key_o   = (rnd == 4'd0);
                en_cipher_o    = (rnd == 4'd0);
                if (rnd == 4'd11) begin
                    en_xor_key_end_o = 1'b1;
                    en_tag_o         = 1'b1;
                    state_n          = S_END;
                    rnd_n            = 4'd0;
                end else begin
                    rnd_n = rnd + 4'd1;
                end
            end
            S_END: begin
                end_o   = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                rnd_n   = 4'd0;
                blk_n   = '0;
            end
        endcase
    end

    assign round_o        = rnd;
    assign cipher_valid_o = cipher_valid_q;
    assign state_o        = state;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm: directed table, hand-written
// corner sequences and random stimulus against a schedule-queue model.
module tb_ascon_ctrl_fsm;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst, st, vld;
    logic       data_ready_o, init_state_o, en_reg_state_o, en_xor_data_o;
    logic       en_xor_key_o, en_xor_key_end_o, en_xor_lsb_end_o;
    logic       en_cipher_o, en_tag_o, cipher_valid_o, end_o;
    logic [3:0] round_o;
    logic [2:0] state_o;
    logic [14:0] act_v;

    int checks = 0;
    int passes = 0;

    ascon_ctrl_fsm #(.NB_BLOCKS(NB)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(st), .data_valid_i(vld),
        .data_ready_o(data_ready_o), .round_o(round_o),
        .init_state_o(init_state_o), .en_reg_state_o(en_reg_state_o),
        .en_xor_data_o(en_xor_data_o), .en_xor_key_o(en_xor_key_o),
        .en_xor_key_end_o(en_xor_key_end_o), .en_xor_lsb_end_o(en_xor_lsb_end_o),
        .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o),
        .cipher_valid_o(cipher_valid_o), .end_o(end_o), .state_o(state_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    assign act_v = {data_ready_o, round_o, init_state_o, en_reg_state_o,
                    en_xor_data_o, en_xor_key_o, en_xor_key_end_o,
                    en_xor_lsb_end_o, en_cipher_o, en_tag_o, cipher_valid_o, end_o};

    // Reference model: a message is a queue of scheduled cycles.
    typedef struct packed {
        logic       wait_s;
        logic [3:0] rnd;
        logic       init_s, en_reg, xd, xk, xke, xle, ec, et, endo;
    } step_t;

    step_t prog[$];
    logic  exp_cv = 1'b0;

    function automatic step_t mk(logic w, logic [3:0] r, logic i, logic e,
                                 logic xd, logic xk, logic xke, logic xle,
                                 logic ec, logic et, logic en);
        step_t s;
        s = '{w, r, i, e, xd, xk, xke, xle, ec, et, en};
        return s;
    endfunction

    function automatic void build_prog();
        prog.delete();
        for (int r = 0; r < 12; r++)
            prog.push_back(mk(0, 4'(r), r == 0, 1, 0, 0, r == 11, 0, 0, 0, 0));
        prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 6; r < 12; r++)
            prog.push_back(mk(0, 4'(r), 0, 1, r == 6, 0, 0, r == 11, 0, 0, 0));
        for (int b = 0; b < NB - 1; b++) begin
            prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int r = 6; r < 12; r++)
                prog.push_back(mk(0, 4'(r), 0, 1, r == 6, 0, 0, 0, r == 6, 0, 0));
        end
        prog.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < 12; r++)
            prog.push_back(mk(0, 4'(r), 0, 1, r == 0, r == 0, r == 11, 0, r == 0, r == 11, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endfunction

    function automatic void model_edge(logic r, logic s, logic v);
        logic cur_ec;
        cur_ec = (prog.size() != 0) ? prog[0].ec : 1'b0;
        if (r) begin
            prog.delete();
            exp_cv = 1'b0;
        end else begin
            exp_cv = cur_ec;
            if (prog.size() == 0) begin
                if (s) build_prog();
            end else if (prog[0].wait_s) begin
                if (v) void'(prog.pop_front());
            end else begin
                void'(prog.pop_front());
            end
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        step_t s;
        if (prog.size() == 0) return {13'd0, exp_cv, 1'b0};
        s = prog[0];
        return {s.wait_s, s.rnd, s.init_s, s.en_reg, s.xd, s.xk, s.xke, s.xle,
                s.ec, s.et, exp_cv, s.endo};
    endfunction

    task automatic check(input string name, input logic [14:0] a, input logic [14:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, a, e, $time);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after.
    task automatic cycle(input logic r, input logic s, input logic v);
        rst = r; st = s; vld = v;
        @(posedge clk);
        model_edge(r, s, v);
        #1;
        check("cycle", act_v, exp_vec());
    endtask

    // Directed table.
    typedef struct {
        logic        r, s, v;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [14:0] mkv(logic rdy, logic [3:0] rn, logic i, logic e, logic xke);
        return {rdy, rn, i, e, 2'b00, xke, 5'b00000};
    endfunction

    int n_ec, n_cv, n_xk, n_tag;
    logic [14:0] tr_ref[64];
    logic [14:0] tr_spur[64];

    // Modes: 0 valid always, 1 stall first WAIT_PT, 2 reset in FINAL,
    // 3 random, 4 spurious start in ASSOC, 5 reference for mode 4.
    task automatic run_msg(input int mode, output int end_cyc);
        logic r, s, v;
        end_cyc = -1;
        n_ec = 0; n_cv = 0; n_xk = 0; n_tag = 0;
        cycle(0, 1, 0);
        for (int k = 2; k <= 200; k++) begin
            r = 0; s = 0; v = 1;
            case (mode)
                1: v = !(k >= 21 && k <= 25);
                2: r = (k == 48);
                3: begin v = ($urandom_range(0, 2) != 0); s = 1'($urandom_range(0, 1)); end
                4: s = (k >= 15 && k <= 20);
                5: v = !(k >= 2 && k <= 13);
                default: ;
            endcase
            cycle(r, s, v);
            if (en_cipher_o) n_ec++;
            if (cipher_valid_o) n_cv++;
            if (en_xor_key_o) n_xk++;
            if (en_tag_o) n_tag++;
            if (k < 64 && mode == 5) tr_ref[k] = act_v;
            if (k < 64 && mode == 4) tr_spur[k] = act_v;
            if (mode == 1 && k >= 21 && k <= 25)
                check("stall_hold", 15'({data_ready_o, round_o, en_reg_state_o}), 15'({1'b1, 4'd0, 1'b0}));
            if (mode == 1 && k == 26)
                check("stall_resume", 15'({data_ready_o, round_o, en_reg_state_o}), 15'({1'b0, 4'd6, 1'b1}));
            if (mode == 2 && k == 47)
                check("final_rnd5", 15'({en_reg_state_o, round_o}), 15'({1'b1, 4'd5}));
            if (mode == 2 && k == 48) begin
                check("reset_final", act_v, 15'd0);
                return;
            end
            if (end_o) begin
                end_cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int ec;
        rst = 1'b1; st = 1'b0; vld = 1'b0;

        // Reset 3 cycles, idle 10, start, 12 init rounds, then WAIT_AD.
        for (int i = 0; i < 3; i++)  tbl[i] = '{1, 0, 0, 15'd0};
        for (int i = 3; i < 13; i++) tbl[i] = '{0, 0, 0, 15'd0};
        tbl[13] = '{0, 1, 0, mkv(0, 0, 1, 1, 0)};
        for (int i = 14; i < 25; i++) tbl[i] = '{0, 0, 1, mkv(0, 4'(i - 13), 0, 1, i == 24)};
        tbl[25] = '{0, 0, 0, mkv(1, 0, 0, 0, 0)};
        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].v);
            check("table", act_v, tbl[i].exp);
        end

        cycle(1, 0, 0);
        cycle(0, 0, 0);
        run_msg(0, ec);
        check("end_cycle", 15'(ec), 15'd54);
        check("n_cipher", 15'(n_ec), 15'd4);
        check("n_cipher_valid", 15'(n_cv), 15'd4);
        check("n_xor_key", 15'(n_xk), 15'd1);
        check("n_tag", 15'(n_tag), 15'd1);
        cycle(0, 1, 0);
        check("start_after_end", act_v, 15'd0);

        run_msg(1, ec);
        check("stall_end_cycle", 15'(ec), 15'd59);

        cycle(0, 0, 0);
        run_msg(2, ec);
        cycle(0, 0, 0);
        check("idle_after_reset", act_v, 15'd0);
        run_msg(0, ec);
        check("replay_end_cycle", 15'(ec), 15'd54);

        cycle(0, 0, 0);
        run_msg(5, ec);
        check("ref_end_cycle", 15'(ec), 15'd54);
        cycle(0, 0, 0);
        run_msg(4, ec);
        check("spur_end_cycle", 15'(ec), 15'd54);
        for (int k = 2; k <= 54; k++) check("spurious_trace", tr_spur[k], tr_ref[k]);

        for (int m = 0; m < 6; m++) begin
            cycle(0, 0, 0);
            run_msg(3, ec);
            check("random_end_seen", 15'(ec > 0), 15'd1);
        end

        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
